// File: rtl/tdm_demux_two.sv
// Receive side of a two-channel TDM link: deserializes frames of word A then word B
// from one serial line and hands each word out on its own valid/ready port.
module tdm_demux_two #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             ser_in,
    input  logic             frame,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             overrun,
    output logic             sync_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RX_A = 2'd1,
        RX_B = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-2:0] shift_r;

    logic [WIDTH-1:0] word_s;
    logic             last_bit_s;
    logic             a_done_s;
    logic             b_done_s;
    logic             resync_s;
    logic             a_load_s;
    logic             b_load_s;

    // Completion and resync decode for the current strobe; word_s already includes this bit.
    always_comb begin
        word_s     = {shift_r, ser_in};
        last_bit_s = (count_r == LAST);
        a_done_s   = ena && !frame && (state_r == RX_A) && last_bit_s;
        b_done_s   = ena && !frame && (state_r == RX_B) && last_bit_s;
        resync_s   = ena && frame && (state_r != HUNT);
        a_load_s   = a_done_s && (!a_valid || a_ready);
        b_load_s   = b_done_s && (!b_valid || b_ready);
    end

    // Framing FSM, shift register and both output holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= HUNT;
            count_r  <= '0;
            shift_r  <= '0;
            a_data   <= '0;
            a_valid  <= 1'b0;
            b_data   <= '0;
            b_valid  <= 1'b0;
            overrun  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= resync_s;
            overrun  <= (a_done_s && a_valid && !a_ready) ||
                        (b_done_s && b_valid && !b_ready);

            if (ena) begin
                case (state_r)
                    HUNT: begin
                        if (frame) begin
                            shift_r <= word_s[WIDTH-2:0];
                            count_r <= ONE;
                            state_r <= RX_A;
                        end else begin
                            state_r <= HUNT;
                        end
                    end
                    RX_A, RX_B: begin
                        shift_r <= word_s[WIDTH-2:0];
                        // A frame marker mid-word restarts reception on A[MSB].
                        if (frame) begin
                            count_r <= ONE;
                            state_r <= RX_A;
                        end else if (last_bit_s) begin
                            count_r <= '0;
                            state_r <= (state_r == RX_A) ? RX_B : HUNT;
                        end else begin
                            count_r <= count_r + ONE;
                        end
                    end
                    default: begin
                        count_r <= '0;
                        state_r <= HUNT;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end

            if (a_load_s) begin
                a_data  <= word_s;
                a_valid <= 1'b1;
            end else if (a_valid && a_ready) begin
                a_valid <= 1'b0;
            end else begin
                a_valid <= a_valid;
            end

            if (b_load_s) begin
                b_data  <= word_s;
                b_valid <= 1'b1;
            end else if (b_valid && b_ready) begin
                b_valid <= 1'b0;
            end else begin
                b_valid <= b_valid;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_two.sv
// Directed bench for tdm_demux_two: hand-computed frames, checked with immediate assertions.
module tb_tdm_demux_two;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       ser_in = 1'b0;
    logic       frame = 1'b0;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready = 1'b0;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready = 1'b0;
    logic       overrun;
    logic       sync_err;

    int n_assert = 0;
    int n_fail   = 0;

    tdm_demux_two #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ser_in(ser_in), .frame(frame),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .overrun(overrun), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are then sampled 1 ns after the edge.
    task automatic drive(input logic e, input logic f, input logic d);
        ena = e;
        frame = f;
        ser_in = d;
        @(posedge clk);
        #1;
    endtask

    // Send one 8-bit word MSB first; optional ena=0 gap (with junk on the line) before each bit.
    task automatic send_word(input logic [7:0] w, input logic fr, input logic gap, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            if (gap) drive(1'b0, 1'b1, ~w[i]);
            if (rdy_last && i == 0) a_ready = 1'b1;
            drive(1'b1, (i == 7) ? fr : 1'b0, w[i]);
            if (fr && i == 7) chk1("sync_err_on_frame_start", sync_err, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] w;

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ena = 1'($urandom);
            frame = 1'($urandom);
            ser_in = 1'($urandom);
            a_ready = 1'($urandom);
            b_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk8("rst_a_data", a_data, 8'h00);
        chk1("rst_a_valid", a_valid, 1'b0);
        chk8("rst_b_data", b_data, 8'h00);
        chk1("rst_b_valid", b_valid, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_sync_err", sync_err, 1'b0);
        rst = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;

        // Continuous strobe, A=A5 B=3C
        drive(1'b0, 1'b0, 1'b0);
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        chk1("t2_a_valid", a_valid, 1'b1);
        chk8("t2_a_data", a_data, 8'hA5);
        chk1("t2_b_valid_early", b_valid, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        chk1("t2_a_consumed", a_valid, 1'b0);
        chk1("t2_b_valid", b_valid, 1'b1);
        chk8("t2_b_data", b_data, 8'h3C);
        chk1("t2_overrun", overrun, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk1("t2_b_consumed", b_valid, 1'b0);

        // Strobe toggling, junk on the line during ena=0
        send_word(8'h5A, 1'b1, 1'b1, 1'b0);
        chk1("t3_a_valid", a_valid, 1'b1);
        chk8("t3_a_data", a_data, 8'h5A);
        send_word(8'hC3, 1'b0, 1'b1, 1'b0);
        chk1("t3_b_valid", b_valid, 1'b1);
        chk8("t3_b_data", b_data, 8'hC3);
        chk1("t3_sync_err", sync_err, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Overrun on A with consumer stalled
        a_ready = 1'b0;
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        chk8("t4_a_data_first", a_data, 8'h11);
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        chk1("t4_a_held", a_valid, 1'b1);
        send_word(8'h22, 1'b1, 1'b0, 1'b0);
        chk1("t4_overrun_pulse", overrun, 1'b1);
        chk8("t4_a_data_kept", a_data, 8'h11);
        chk1("t4_a_valid_kept", a_valid, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk1("t4_overrun_single", overrun, 1'b0);
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b1);
        chk8("t4_a_data_replaced", a_data, 8'h22);
        chk1("t4_a_valid_replaced", a_valid, 1'b1);
        chk1("t4_no_overrun", overrun, 1'b0);
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        chk1("t4_a_consumed", a_valid, 1'b0);

        // Resync at B bit 3
        send_word(8'h77, 1'b1, 1'b0, 1'b0);
        chk8("t5_a_data_first", a_data, 8'h77);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        w = 8'hE1;
        drive(1'b1, 1'b1, w[7]);
        chk1("t5_sync_err_pulse", sync_err, 1'b1);
        chk1("t5_b_discarded", b_valid, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, 1'b0, w[i]);
            if (i == 6) chk1("t5_sync_err_single", sync_err, 1'b0);
        end
        chk1("t5_a_valid", a_valid, 1'b1);
        chk8("t5_a_data", a_data, 8'hE1);
        send_word(8'h4B, 1'b0, 1'b0, 1'b0);
        chk1("t5_b_valid", b_valid, 1'b1);
        chk8("t5_b_data", b_data, 8'h4B);

        // Back-to-back frame marker right after B is legal; then reset mid-B
        w = 8'h0F;
        drive(1'b1, 1'b1, w[7]);
        chk1("t6_legal_frame_no_sync_err", sync_err, 1'b0);
        a_ready = 1'b0;
        for (int i = 6; i >= 0; i--) drive(1'b1, 1'b0, w[i]);
        chk8("t6_a_data_pre", a_data, 8'h0F);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
        chk1("t6_a_valid_pre", a_valid, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        chk1("t6_rst_a_valid", a_valid, 1'b0);
        chk8("t6_rst_a_data", a_data, 8'h00);
        chk1("t6_rst_b_valid", b_valid, 1'b0);
        a_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk1("t6_hunt_ignores_bits", a_valid, 1'b0);
        send_word(8'hC5, 1'b1, 1'b0, 1'b0);
        chk1("t6_a_valid", a_valid, 1'b1);
        chk8("t6_a_data", a_data, 8'hC5);
        send_word(8'h3A, 1'b0, 1'b0, 1'b0);
        chk1("t6_b_valid", b_valid, 1'b1);
        chk8("t6_b_data", b_data, 8'h3A);
        chk1("t6_sync_err", sync_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
